// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-read data RAM between two
// valid/ready masters, with byte-strobe read-modify-write. Optional DMEM_ARB_STATS_EN adds a conflict counter.
module dmem_arbiter #(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_valid,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [31:0]          m0_wdata,
  input  logic [3:0]           m0_wstrb,
  output logic                 m0_ready,
  output logic [31:0]          m0_rdata,
  input  logic                 m1_valid,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [31:0]          m1_wdata,
  input  logic [3:0]           m1_wstrb,
  output logic                 m1_ready,
  output logic [31:0]          m1_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]          stat_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, RD, RMW, ACK} state_t;

  state_t                 state, state_nx;
  logic                   sel, last;
  logic                   any_valid, both_valid, gnt, cur;
  logic [ADDR_BITS-1:0]   req_addr;
  logic [31:0]            req_wdata, merged;
  logic [3:0]             req_wstrb;

  // Grant: lone requester wins; on a tie the port that was not served last wins.
  always_comb begin
    any_valid  = m0_valid | m1_valid;
    both_valid = m0_valid & m1_valid;
    if (both_valid) gnt = ~last;
    else            gnt = m1_valid;
    cur = (state == IDLE) ? gnt : sel;
  end

  always_comb begin
    req_addr  = cur ? m1_addr  : m0_addr;
    req_wdata = cur ? m1_wdata : m0_wdata;
    req_wstrb = cur ? m1_wstrb : m0_wstrb;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = req_wstrb[i] ? req_wdata[8*i +: 8] : ram_rdata[8*i +: 8];
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_nx  = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    case (state)
      IDLE: if (any_valid) begin
        ram_en = 1'b1;
        if (req_wstrb == 4'hF) begin
          ram_we   = 1'b1;
          state_nx = ACK;
        end else if (req_wstrb == 4'h0) begin
          state_nx = RD;
        end else begin
          state_nx = RMW;
        end
      end
      RD:  state_nx = ACK;
      RMW: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = merged;
        state_nx  = ACK;
      end
      ACK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Reset aborts in the same cycle, so a pending write never reaches the RAM.
    if (reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  assign m0_ready = (state == ACK) && !sel && !reset;
  assign m1_ready = (state == ACK) &&  sel && !reset;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last     <= 1'b1;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_valid) begin
        sel  <= gnt;
        last <= gnt;
      end
      if (state == RD) begin
        if (sel) m1_rdata <= ram_rdata;
        else     m0_rdata <= ram_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stat_conflicts <= '0;
    else if (state == IDLE && both_valid && stat_conflicts != 16'hFFFF)
      stat_conflicts <= stat_conflicts + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural 1-cycle BSRAM model, two requesters,
// hand-computed expected values. Build with DMEM_ARB_STATS_EN to also check the conflict counter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [8:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflicts;
`endif

  dmem_arbiter #(.ADDR_BITS(9)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // RAM model with a backdoor preload port
  logic [31:0] mem [512];
  logic        pre_en = 1'b0;
  logic [8:0]  pre_addr;
  logic [31:0] pre_data;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    if (ram_en && ram_we)  mem[ram_addr] <= ram_wdata;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-port, per-cycle trace of the last request (index 1 = grant cycle)
  logic        tr_en [2][32];
  logic        tr_we [2][32];
  logic [31:0] tr_wd [2][32];

  // Ready log for the arbitration test
  bit  log_en = 0;
  int  cyc = 0;
  int  rq_port[$];
  int  rq_cyc[$];
  always @(negedge clk) begin
    cyc++;
    if (log_en) begin
      if (m0_ready) begin rq_port.push_back(0); rq_cyc.push_back(cyc); end
      if (m1_ready) begin rq_port.push_back(1); rq_cyc.push_back(cyc); end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_port(input int p);
    if (p == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  // Present a request at the current cycle and wait (bounded) for its ready.
  // Returns one cycle after ready, with the request signals still driven.
  task automatic do_req(input int p, input logic [8:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit chk_oth,
                        output int lat, output logic [31:0] rd);
    bit done;
    if (p == 0) begin m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; end
    else        begin m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; end
    lat = -1; rd = '0; done = 0;
    for (int n = 1; n < 32 && !done; n++) begin
      @(negedge clk);
      tr_en[p][n] = ram_en; tr_we[p][n] = ram_we; tr_wd[p][n] = ram_wdata;
      if (chk_oth) check("other_ready_low", (p == 0) ? m1_ready : m0_ready, 0);
      if ((p == 0) ? m0_ready : m1_ready) begin
        lat  = n - 1;
        rd   = (p == 0) ? m0_rdata : m1_rdata;
        done = 1;
        check("ack_ram_en_low", ram_en, 0);
      end
    end
    if (!done) check("ready_timeout", 0, 1);
    step();
  endtask

  task automatic rd_thread(input int p, input logic [8:0] a, input logic [31:0] exp);
    int lat; logic [31:0] rd;
    for (int k = 0; k < 2; k++) begin
      do_req(p, a, 32'h0, 4'h0, 1'b0, lat, rd);
      check(p == 0 ? "rr_m0_rdata" : "rr_m1_rdata", rd, exp);
      idle_port(p);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] rd;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] s0;
`endif
    reset = 1'b1;
    m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    step();
    preload(9'd5,  32'h11223344);
    preload(9'd9,  32'h55667788);
    preload(9'd10, 32'hA0A00010);
    preload(9'd11, 32'hB1B10011);
    @(negedge clk);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
`ifdef DMEM_ARB_STATS_EN
    check("rst_stats", stat_conflicts, 0);
`endif
    step();
    reset = 1'b0;

    // m0 read of word 5
    do_req(0, 9'd5, 32'h0, 4'h0, 1'b1, lat, rd);
    check("rd_lat", lat, 2);
    check("rd_data", rd, 32'h11223344);
    check("rd_grant_en", tr_en[0][1], 1);
    check("rd_grant_we", tr_we[0][1], 0);
    check("rd_m1_rdata_kept", m1_rdata, 0);
    idle_port(0); step();

    // m1 full write to word 7, then readback
    do_req(1, 9'd7, 32'hCAFEBABE, 4'hF, 1'b1, lat, rd);
    check("fw_lat", lat, 1);
    check("fw_grant_we", tr_we[1][1], 1);
    check("fw_grant_wdata", tr_wd[1][1], 32'hCAFEBABE);
    check("fw_mem", mem[7], 32'hCAFEBABE);
    check("fw_m1_rdata_kept", m1_rdata, 0);
    idle_port(1); step();
    do_req(1, 9'd7, 32'h0, 4'h0, 1'b1, lat, rd);
    check("fw_readback", rd, 32'hCAFEBABE);
    check("fw_m0_rdata_kept", m0_rdata, 32'h11223344);
    idle_port(1); step();

    // m0 partial write to word 5, strobes 0101
    do_req(0, 9'd5, 32'hAABBCCDD, 4'b0101, 1'b1, lat, rd);
    check("pw_lat", lat, 2);
    check("pw_grant_en", tr_en[0][1], 1);
    check("pw_grant_we", tr_we[0][1], 0);
    check("pw_rmw_we", tr_we[0][2], 1);
    check("pw_rmw_wdata", tr_wd[0][2], 32'h11BB33DD);
    check("pw_m0_rdata_kept", m0_rdata, 32'h11223344);
    idle_port(0); step();
    do_req(0, 9'd5, 32'h0, 4'h0, 1'b1, lat, rd);
    check("pw_readback", rd, 32'h11BB33DD);
    idle_port(0); step();

    // Both ports stream reads after a fresh reset: m0 first, then alternation
    reset = 1'b1; step(); reset = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    s0 = stat_conflicts;
`endif
    rq_port.delete(); rq_cyc.delete();
    log_en = 1;
    fork
      rd_thread(0, 9'd10, 32'hA0A00010);
      rd_thread(1, 9'd11, 32'hB1B10011);
    join
    log_en = 0;
    check("rr_count", rq_port.size(), 4);
    for (int i = 0; i < 4 && i < rq_port.size(); i++) begin
      check("rr_order", rq_port[i], i % 2);
      if (i > 0) check("rr_spacing", rq_cyc[i] - rq_cyc[i-1], 3);
    end
`ifdef DMEM_ARB_STATS_EN
    check("rr_stats", stat_conflicts - s0, 2);
`endif

    // Reset during the RMW cycle of a partial write to word 9
    m0_valid = 1'b1; m0_addr = 9'd9; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'b0011;
    @(negedge clk);
    check("rst_rmw_idle_en", ram_en, 1);
    check("rst_rmw_idle_we", ram_we, 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_rmw_we", ram_we, 0);
    check("rst_rmw_ready", m0_ready, 0);
    step();
    reset = 1'b0;
    m0_valid = 1'b0;
    do_req(1, 9'd11, 32'h0, 4'h0, 1'b1, lat, rd);
    check("rst_m1_lat", lat, 2);
    check("rst_m1_rdata", rd, 32'hB1B10011);
    check("rst_word_kept", mem[9], 32'h55667788);
    idle_port(1); step();

    // Back-to-back m0 full writes, new request presented right after each ready
    for (int i = 0; i < 4; i++) begin
      do_req(0, 9'(i), 32'h10000000 + 32'(i), 4'hF, 1'b1, lat, rd);
      check("b2b_lat", lat, 1);
    end
    idle_port(0); step();
    for (int i = 0; i < 4; i++) check("b2b_mem", mem[i], 32'h10000000 + 32'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
